// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, presents one instruction at a time.
// Optional misaligned jr trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  input  logic        branch,
  input  logic        n_branch,
  input  logic        jmp,
  input  logic        jal,
  input  logic        jrn,
  input  logic        zero,
  input  logic [31:0] read_data_1,
  output logic        fetch_err
);

  // state | meaning
  // REQ   | request outstanding at pc, waiting for imem_ack
  // HOLD  | instruction presented, waiting for inst_ready
  // HALT  | misaligned jr trapped, stopped until reset
  typedef enum logic [1:0] {REQ, HOLD, HALT} state_t;

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        req_armed_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] link_q, link_d;
  logic        err_q, err_d;

  logic [31:0] jr_target, jump_target, branch_target;
  logic        take_branch, misalign;

  always_comb begin
    jr_target     = {read_data_1[31:2], 2'b00};
    misalign      = |read_data_1[1:0];
    jump_target   = {link_q[31:28], instr_q[25:0], 2'b00};
    branch_target = link_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    take_branch   = (branch & zero) | (n_branch & ~zero);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    link_d  = link_q;
    err_d   = err_q;
    case (state_q)
      REQ: begin
        // req_armed_q keeps a stray ack from being taken in the reset-release cycle
        if (req_armed_q && imem_ack) begin
          instr_d = imem_rdata;
          link_d  = pc_q + 32'd4;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          state_d = REQ;
          if (jrn) begin
            if (TRAP_EN && misalign) begin
              err_d   = 1'b1;
              state_d = HALT;
            end else begin
              pc_d = jr_target;
            end
          end else if (jmp || jal) begin
            pc_d = jump_target;
          end else if (take_branch) begin
            pc_d = branch_target;
          end else begin
            pc_d = link_q;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      req_armed_q <= 1'b0;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      link_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_armed_q <= 1'b1;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      link_q      <= link_d;
      err_q       <= err_d;
    end
  end

  assign imem_req    = req_armed_q && (state_q == REQ);
  assign imem_addr   = pc_q;
  assign inst_valid  = (state_q == HOLD);
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign link_addr   = link_q;
  assign fetch_err   = TRAP_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: driver pushes expected pc/instruction/link, monitor pops on presentation.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        branch, n_branch, jmp, jal, jrn, zero;
  logic [31:0] read_data_1;
  logic        fetch_err;

  always #5 clock = ~clock;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .pc(pc), .link_addr(link_addr),
    .branch(branch), .n_branch(n_branch), .jmp(jmp), .jal(jal), .jrn(jrn),
    .zero(zero), .read_data_1(read_data_1), .fetch_err(fetch_err)
  );

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] JR   = 5'b10000;
  localparam logic [4:0] J    = 5'b01000;
  localparam logic [4:0] JAL  = 5'b00100;
  localparam logic [4:0] BEQ  = 5'b00010;
  localparam logic [4:0] BNE  = 5'b00001;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] link;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: one pop per presented instruction, on the first cycle inst_valid is seen high.
  logic seen = 1'b0;
  always @(negedge clock) begin
    if (!rst_n || !inst_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      exp_t e;
      seen = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'd0, inst_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("mon_pc", pc, e.pc);
        chk("mon_instruction", instruction, e.instr);
        chk("mon_link_addr", link_addr, e.link);
      end
    end
  end

  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] word,
                       input int ack_dly, input int hold,
                       input logic [4:0] ctl, input logic z, input logic [31:0] rd1);
    int n;
    n = 0;
    sb.push_back('{exp_pc, word, exp_pc + 32'd4});
    while (!imem_req && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("imem_addr", imem_addr, exp_pc);
    repeat (ack_dly) begin
      @(posedge clock); #1;
      chk("req_held_addr", {imem_req, imem_addr[30:0]}, {1'b1, exp_pc[30:0]});
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(posedge clock); #1;
    imem_ack = 1'b0;
    for (int i = 0; i < hold; i++) begin
      imem_ack = (i % 2 == 0);
      imem_rdata = 32'hBAD0_0000 | i;
      @(posedge clock); #1;
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instruction", instruction, word);
      chk("hold_pc", pc, exp_pc);
      chk("hold_link_addr", link_addr, exp_pc + 32'd4);
    end
    imem_ack = 1'b0;
    {jrn, jmp, jal, branch, n_branch} = ctl;
    zero = z;
    read_data_1 = rd1;
    inst_ready = 1'b1;
    @(posedge clock); #1;
    inst_ready = 1'b0;
    {jrn, jmp, jal, branch, n_branch} = NONE;
    zero = 1'b0;
    read_data_1 = 32'h0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    {jrn, jmp, jal, branch, n_branch} = NONE;
    zero = 1'b0;
    read_data_1 = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_link_addr", link_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    chk("req_low_at_release", {31'd0, imem_req}, 32'd0);

    fetch(32'h0000_0000, 32'h2008_0005, 2, 0, NONE, 1'b0, 32'h0);
    fetch(32'h0000_0004, 32'h0000_0020, 0, 5, JR,   1'b0, 32'h0000_0040);
    fetch(32'h0000_0040, 32'h1000_FFFE, 1, 0, BEQ,  1'b1, 32'h0);
    fetch(32'h0000_003C, 32'h0000_0008, 0, 0, JR,   1'b0, 32'h0000_0040);
    fetch(32'h0000_0040, 32'h1000_FFFE, 0, 0, BEQ,  1'b0, 32'h0);
    fetch(32'h0000_0044, 32'h0000_0008, 0, 1, JR,   1'b0, 32'h0000_0040);
    fetch(32'h0000_0040, 32'h1400_0003, 0, 0, BNE,  1'b0, 32'h0);
    fetch(32'h0000_0050, 32'h0000_0008, 0, 0, JR,   1'b0, 32'h1000_0000);
    fetch(32'h1000_0000, 32'h0800_0010, 0, 0, J,    1'b0, 32'h0);
    fetch(32'h1000_0040, 32'h0000_0008, 0, 0, JR,   1'b0, 32'h1000_0000);
    fetch(32'h1000_0000, 32'h0C00_0010, 0, 0, JAL,  1'b0, 32'h0);
    fetch(32'h1000_0040, 32'h0BFF_FFFF, 0, 0, JR | J, 1'b0, 32'h0000_0200);
    fetch(32'h0000_0200, 32'h0000_0008, 0, 0, JR,   1'b0, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, NONE, 1'b0, 32'h0);
    fetch(32'h0000_0000, 32'h0000_0008, 0, 0, JR,   1'b0, 32'h0000_0203);

`ifdef IFETCH_MISALIGN_TRAP_EN
    repeat (4) @(posedge clock);
    #1;
    chk("trap_fetch_err", {31'd0, fetch_err}, 32'd1);
    chk("trap_imem_req", {31'd0, imem_req}, 32'd0);
    chk("trap_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("trap_pc", pc, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("trap_cleared_by_reset", {31'd0, fetch_err}, 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    n = 0;
    while (!imem_req && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("post_trap_addr", imem_addr, 32'h0);
`else
    chk("no_trap_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("jr_aligned_addr", imem_addr, 32'h0000_0200);
`endif

    // Reset lands in the same cycle as an ack: the ack must be lost.
    n = 0;
    while (!imem_req && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("pre_reset_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instruction", instruction, 32'h0);
    @(posedge clock); #1;
    imem_ack = 1'b0;
    chk("rst_ack_discarded", instruction, 32'h0);
    chk("rst_inst_valid2", {31'd0, inst_valid}, 32'd0);
    rst_n = 1'b1;

    fetch(32'h0000_0000, 32'h1234_5678, 0, 0, NONE, 1'b0, 32'h0);
    fetch(32'h0000_0004, 32'h8765_4321, 1, 2, NONE, 1'b0, 32'h0);
    n = 0;
    while (!imem_req && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    chk("final_seq_addr", imem_addr, 32'h0000_0008);
    repeat (2) @(posedge clock);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
